// File: rtl/omsp_spm_key_writer.sv
// rtl/omsp_spm_key_writer.sv - Sancus SPM key write sequencer with secure wipe on abort
// Streams N 16-bit key words into the SPM key port; abort overwrites all N slots with zero.
module omsp_spm_key_writer #(
  parameter int SECURITY     = 64,
  parameter int KEY_IDX_SIZE = 2
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [15:0]             word_in,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic                    write_key,
  output logic [15:0]             key_word,
  output logic [KEY_IDX_SIZE-1:0] key_idx,
  output logic                    busy,
  output logic                    done,
  output logic                    aborted
);

  localparam int N  = SECURITY / 16;
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WIPE} state_t;

  state_t                  r_state;
  logic [CW-1:0]           r_cnt;
  logic [CW-1:0]           r_wcnt;
  logic                    r_write_key;
  logic [15:0]             r_key_word;
  logic [KEY_IDX_SIZE-1:0] r_key_idx;
  logic                    r_done;
  logic                    r_aborted;

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_wcnt      <= '0;
      r_write_key <= 1'b0;
      r_key_word  <= '0;
      r_key_idx   <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
    end else begin
      // Write-port registers fall back to zero so no key data lingers on key_word.
      r_write_key <= 1'b0;
      r_key_word  <= '0;
      r_key_idx   <= '0;
      r_done      <= 1'b0;
      r_aborted   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_LOAD;
            r_cnt   <= '0;
          end
        end
        S_LOAD: begin
          if (abort) begin
            // The word offered alongside abort is dropped; slot 0 is wiped instead.
            r_write_key <= 1'b1;
            r_wcnt      <= CW'(1);
            if (LAST == '0) begin
              r_aborted <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_state <= S_WIPE;
            end
          end else if (word_valid) begin
            r_write_key <= 1'b1;
            r_key_word  <= word_in;
            r_key_idx   <= KEY_IDX_SIZE'(r_cnt);
            r_cnt       <= r_cnt + CW'(1);
            if (r_cnt == LAST) begin
              r_done  <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
        S_WIPE: begin
          r_write_key <= 1'b1;
          r_key_idx   <= KEY_IDX_SIZE'(r_wcnt);
          r_wcnt      <= r_wcnt + CW'(1);
          if (r_wcnt == LAST) begin
            r_aborted <= 1'b1;
            r_state   <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign word_ready = (r_state == S_LOAD);
  assign busy       = (r_state != S_IDLE);
  assign write_key  = r_write_key;
  assign key_word   = r_key_word;
  assign key_idx    = r_key_idx;
  assign done       = r_done;
  assign aborted    = r_aborted;

endmodule

// File: tb/tb_omsp_spm_key_writer.sv
// tb/tb_omsp_spm_key_writer.sv - self-checking bench for omsp_spm_key_writer
// Per-cycle stimulus tables are replayed and compared against a schedule-based reference.
module tb_omsp_spm_key_writer;
  localparam int N   = 4;
  localparam int MAX = 64;

  logic        mclk = 1'b0;
  logic        puc_rst, start, abort, word_valid;
  logic [15:0] word_in;
  logic        word_ready, write_key, busy, done, aborted;
  logic [15:0] key_word;
  logic [1:0]  key_idx;

  omsp_spm_key_writer #(.SECURITY(64), .KEY_IDX_SIZE(2)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .start(start), .abort(abort),
    .word_in(word_in), .word_valid(word_valid), .word_ready(word_ready),
    .write_key(write_key), .key_word(key_word), .key_idx(key_idx),
    .busy(busy), .done(done), .aborted(aborted)
  );

  always #5 mclk = ~mclk;

  int          tests = 0;
  int          fails = 0;
  int          L;
  logic        s_rst[MAX], s_start[MAX], s_abort[MAX], s_valid[MAX];
  logic [15:0] s_word[MAX];
  // {write_key, key_word, key_idx, done, aborted, busy, word_ready}
  logic [22:0] obs_v[MAX], exp_v[MAX];

  function automatic logic [22:0] mk(logic wk, logic [15:0] w, int idx, logic d, logic a,
                                     logic b, logic r);
    logic [1:0] i2;
    i2 = idx[1:0];
    return {wk, w, i2, d, a, b, r};
  endfunction

  task automatic clear_stim(input int len);
    L = len;
    for (int c = 0; c < MAX; c++) begin
      s_rst[c] = 0; s_start[c] = 0; s_abort[c] = 0; s_valid[c] = 0; s_word[c] = 16'h0;
    end
  endtask

  task automatic put_word(input int c, input logic [15:0] w);
    s_valid[c] = 1'b1;
    s_word[c]  = w;
  endtask

  // obs_v[c] holds outputs sampled just after the edge where stimulus c was applied.
  task automatic run_stim();
    @(negedge mclk);
    puc_rst = 1; start = 0; abort = 0; word_valid = 0; word_in = 16'h0;
    @(posedge mclk);
    for (int c = 0; c < L; c++) begin
      @(negedge mclk);
      puc_rst = s_rst[c]; start = s_start[c]; abort = s_abort[c];
      word_valid = s_valid[c]; word_in = s_word[c];
      @(posedge mclk);
      #1;
      obs_v[c] = {write_key, key_word, key_idx, done, aborted, busy, word_ready};
    end
    @(negedge mclk);
    puc_rst = 0; start = 0; abort = 0; word_valid = 0; word_in = 16'h0;
  endtask

  // Reference: a load collects N accepted words; an abort schedules N zero writes
  // into the following cycles and blinds the block to inputs until they finish.
  task automatic build_exp();
    int  loading = 0;
    int  k       = 0;
    int  free_at = 0;
    for (int c = 0; c < L; c++) exp_v[c] = '0;
    for (int c = 0; c < L; c++) begin
      if (s_rst[c]) begin
        for (int j = c; j < L; j++) exp_v[j] = '0;
        loading = 0; k = 0; free_at = c + 1;
      end else if (c >= free_at) begin
        if (!loading) begin
          if (s_start[c]) begin loading = 1; k = 0; end
          exp_v[c] = mk(0, 16'h0, 0, 0, 0, loading != 0, loading != 0);
        end else if (s_abort[c]) begin
          for (int j = 0; j < N; j++)
            if (c + j < L) exp_v[c+j] = mk(1, 16'h0, j, 0, j == N-1, j < N-1, 0);
          loading = 0; free_at = c + N;
        end else if (s_valid[c]) begin
          k++;
          if (k == N) loading = 0;
          exp_v[c] = mk(1, s_word[c], k-1, k == N, 0, loading != 0, loading != 0);
        end else begin
          exp_v[c] = mk(0, 16'h0, 0, 0, 0, 1, 1);
        end
      end
    end
  endtask

  task automatic test_reset();
    @(negedge mclk);
    puc_rst = 1; start = 1; abort = 1; word_valid = 1; word_in = 16'h1234;
    @(posedge mclk); #1;
    tests++;
    if ({write_key, key_word, key_idx, done, aborted, busy, word_ready} !== 23'h0) begin
      fails++;
      $display("FAIL reset_state got %h exp 0",
               {write_key, key_word, key_idx, done, aborted, busy, word_ready});
    end
    clear_stim(10);
    for (int c = 5; c < 10; c++) put_word(c, 16'hFFFF);
    run_stim(); build_exp();
    for (int c = 0; c < L; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c] || obs_v[c] !== 23'h0) begin
        fails++; $display("FAIL idle cyc%0d got %h exp %h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    clear_stim(8);
    s_start[0] = 1;
    put_word(1, 16'h1111); put_word(2, 16'h2222); put_word(3, 16'h3333); put_word(4, 16'h4444);
    run_stim(); build_exp();
    for (int c = 0; c < L; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++; $display("FAIL b2b cyc%0d got %h exp %h", c, obs_v[c], exp_v[c]);
      end
    end
    tests++;
    if (obs_v[4] !== mk(1, 16'h4444, 3, 1, 0, 0, 0)) begin
      fails++; $display("FAIL b2b_done got %h exp %h", obs_v[4], mk(1, 16'h4444, 3, 1, 0, 0, 0));
    end
  endtask

  task automatic test_stalled();
    clear_stim(14);
    s_start[0] = 1;
    put_word(1, 16'hA001); put_word(5, 16'hA002); put_word(6, 16'hA003); put_word(8, 16'hA004);
    run_stim(); build_exp();
    for (int c = 0; c < L; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++; $display("FAIL stall cyc%0d got %h exp %h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_abort();
    clear_stim(10);
    s_start[0] = 1;
    put_word(1, 16'h5A01); put_word(2, 16'h5A02); put_word(3, 16'hBEEF); s_abort[3] = 1;
    run_stim(); build_exp();
    for (int c = 0; c < L; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++; $display("FAIL abort cyc%0d got %h exp %h", c, obs_v[c], exp_v[c]);
      end
      tests++;
      if (obs_v[c][22] === 1'b1 && obs_v[c][21:6] === 16'hBEEF || obs_v[c][3] !== 1'b0) begin
        fails++; $display("FAIL abort_leak cyc%0d got %h exp no BEEF/done", c, obs_v[c]);
      end
    end
    tests++;
    if (obs_v[6] !== mk(1, 16'h0, 3, 0, 1, 0, 0)) begin
      fails++; $display("FAIL abort_last got %h exp %h", obs_v[6], mk(1, 16'h0, 3, 0, 1, 0, 0));
    end
  endtask

  task automatic test_ignored_inputs();
    clear_stim(16);
    s_start[0] = 1;
    put_word(1, 16'hC000); s_start[2] = 1; put_word(2, 16'hC001);
    put_word(3, 16'hC002); put_word(4, 16'hC003);
    s_start[5] = 1; put_word(6, 16'hD000); s_abort[7] = 1;
    s_start[8] = 1; s_abort[9] = 1; s_start[9] = 1; put_word(9, 16'hD0D0); s_abort[10] = 1;
    s_start[11] = 1; put_word(12, 16'hE000);
    run_stim(); build_exp();
    for (int c = 0; c < L; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++; $display("FAIL ignore cyc%0d got %h exp %h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_reset_mid_load();
    clear_stim(12);
    s_start[0] = 1; put_word(1, 16'h7001); s_rst[2] = 1;
    s_start[3] = 1;
    put_word(4, 16'h7101); put_word(5, 16'h7102); put_word(6, 16'h7103); put_word(7, 16'h7104);
    run_stim(); build_exp();
    for (int c = 0; c < L; c++) begin
      tests++;
      if (obs_v[c] !== exp_v[c]) begin
        fails++; $display("FAIL rst_mid cyc%0d got %h exp %h", c, obs_v[c], exp_v[c]);
      end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      clear_stim(48);
      for (int c = 0; c < L; c++) begin
        s_start[c] = ($urandom_range(3) == 0);
        s_abort[c] = ($urandom_range(11) == 0);
        s_rst[c]   = ($urandom_range(39) == 0);
        s_valid[c] = ($urandom_range(1) == 0);
        s_word[c]  = 16'($urandom);
      end
      run_stim(); build_exp();
      for (int c = 0; c < L; c++) begin
        tests++;
        if (obs_v[c] !== exp_v[c]) begin
          fails++; $display("FAIL rand%0d cyc%0d got %h exp %h", r, c, obs_v[c], exp_v[c]);
        end
      end
    end
  endtask

  initial begin
    puc_rst = 1; start = 0; abort = 0; word_valid = 0; word_in = 16'h0;
    repeat (2) @(posedge mclk);
    test_reset();
    test_back_to_back();
    test_stalled();
    test_abort();
    test_ignored_inputs();
    test_reset_mid_load();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/omsp_spm_key_writer.md
# omsp_spm_key_writer

Sequencer directly upstream of the SPM control block: accepts a Sancus module key as a stream of 16-bit words from the key-derivation/crypto unit and drives the key write port of the SPM array (write_key / key word / key index), one word per cycle. It owns word counting, stream back-pressure, completion signalling and a secure abort path that overwrites every key slot with zero, so a partially written key never survives in an SPM.

## Interface
Parameters:
- SECURITY, 64, key width in bits; multiple of 16; N = SECURITY/16 words per key
- KEY_IDX_SIZE, 2, width of key_idx; must satisfy N <= 2^KEY_IDX_SIZE

Ports:
- mclk  in  1  clock; one clock, all state on its rising edge
- puc_rst  in  1  reset, synchronous, active-high
- start  in  1  single-cycle request to begin loading a key
- abort  in  1  cancel an in-progress load and wipe the key slots
- word_in  in  16  key word from crypto unit, word 0 first
- word_valid  in  1  word_in valid
- word_ready  out  1  block accepts word_in this cycle
- write_key  out  1  key write strobe to SPM control
- key_word  out  16  data for key write
- key_idx  out  KEY_IDX_SIZE  word index of key write
- busy  out  1  state is LOAD or WIPE
- done  out  1  single-cycle pulse: all N words written
- aborted  out  1  single-cycle pulse: wipe finished

## Operation
- States: IDLE, LOAD, WIPE. Reset -> IDLE.
- IDLE: start=1 -> LOAD, word counter cnt <= 0. abort ignored.
- LOAD: word_ready = 1 (combinational from state only, not from word_valid). Accept = word_valid & word_ready & ~abort.
  - On accept: register write_key<=1, key_word<=word_in, key_idx<=cnt; cnt<=cnt+1.
  - Accept with cnt == N-1: also done<=1, state -> IDLE.
  - abort=1 (priority over simultaneous accept; that word is dropped, not written): state -> WIPE, register write_key<=1, key_word<=0, key_idx<=0, wipe counter wcnt<=1.
  - start in LOAD ignored.
- WIPE: word_ready=0. Each cycle while wcnt < N: write_key<=1, key_word<=0, key_idx<=wcnt, wcnt<=wcnt+1. When wcnt == N-1 is issued, also aborted<=1, state -> IDLE. start and abort ignored in WIPE.
- All slots 0..N-1 are wiped regardless of how many words were loaded before abort.
- Counters are $clog2(N)+1 bits wide internally; key_idx is the low KEY_IDX_SIZE bits; no wrap-around occurs since cnt/wcnt never exceed N-1 on a write.
- write_key, key_word, key_idx, done, aborted are registers; when not written they return to write_key=0, key_word=0, key_idx=0, done=0, aborted=0 (no stale data on key_word).
- busy = (state != IDLE), combinational.
- start in IDLE coincident with abort: start wins (abort meaningless in IDLE).

## Timing
- Reset values: write_key=0, key_word=0, key_idx=0, done=0, aborted=0, busy=0, word_ready=0; state IDLE, counters 0.
- Reset asserted mid-LOAD or mid-WIPE: next edge returns to IDLE with all outputs 0; no wipe performed (SPM state is cleared by the same reset).
- start at edge t -> busy and word_ready high from cycle t+1.
- Word accepted at cycle t -> write_key/key_word/key_idx valid in cycle t+1 (latency 1); throughput 1 word/cycle.
- Last word accepted at t -> done=1 and final write_key in t+1; busy=0, word_ready=0 in t+1; a new start in t+1 is accepted.
- abort at t in LOAD -> wipe writes in cycles t+1..t+N (idx 0..N-1), aborted=1 in cycle t+N, busy=0 in t+N.
- word_valid gaps in LOAD: state holds, no write, no timeout.

## Test plan
- Reset then idle: all outputs 0 for 5 cycles; word_valid=1 with word_in=16'hFFFF in IDLE -> no write_key, word_ready=0.
- Back-to-back load (N=4): start, then words 16'h1111,2222,3333,4444 on consecutive cycles -> write_key at idx 0..3 with those values one cycle after each accept; done pulse with idx 3; busy drops same cycle.
- Stalled stream: words 16'hA001, gap 3 cycles, 16'hA002, 16'hA003, gap, 16'hA004 -> writes only on accept+1, idx 0..3 in order, done after 4th.
- Abort after 2 words, abort coincident with valid 3rd word 16'hBEEF -> BEEF never appears; 4 writes of 16'h0000 at idx 0..3 on consecutive cycles, aborted on idx 3, done never asserted.
- start during LOAD and start/abort during WIPE -> ignored, sequences identical to undisturbed case; start in cycle after done -> new load begins.
- puc_rst mid-LOAD after 1 word -> next cycle all outputs 0, busy=0, no wipe writes; subsequent full load completes normally.
